// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared definitions for the perceptron training sequencer: FSM state
// encoding and default sizing for the sample walk and epoch counters.
package perceptron_train_ctrl_pkg;

    // One state per phase of the 3-cycle sample walk, plus epoch wrap-up.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_LOAD      = 3'd2,
        S_EVAL      = 3'd3,
        S_EPOCH_END = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int DEF_NSAMPLES  = 100;
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_MAX_EPOCH = 64;
    localparam int DEF_EPOCH_W   = 7;

endpackage

// File: rtl/perceptron_sample_cnt.sv
// Sample index counter for the epoch walk. Counts 0..NSAMPLES-1, flags the
// last sample and stops there; a synchronous clear restarts the walk.
module perceptron_sample_cnt
    import perceptron_train_ctrl_pkg::*;
#(
    parameter int NSAMPLES = DEF_NSAMPLES,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    logic [ADDR_W-1:0] idx_q, idx_d;

    assign last = (idx_q == ADDR_W'(NSAMPLES - 1));
    assign idx  = idx_q;

    // Next index: clear wins, otherwise step unless already on the last sample.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc && !last) begin
            idx_d = idx_q + ADDR_W'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Sequencing FSM for single-layer perceptron training. Walks the sample
// memory once per epoch (ADDR -> LOAD -> EVAL per sample), fires a weight
// update on every misclassification, and stops on the first error-free
// epoch or when the epoch limit is reached.
module perceptron_train_ctrl
    import perceptron_train_ctrl_pkg::*;
#(
    parameter int NSAMPLES  = DEF_NSAMPLES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_EPOCH = DEF_MAX_EPOCH,
    parameter int EPOCH_W   = DEF_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               eq,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic               ldX1,
    output logic               ldX2,
    output logic               ldT,
    output logic               ldW1,
    output logic               ldW2,
    output logic               ldB,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic [EPOCH_W-1:0] err_count
);

    localparam logic [EPOCH_W:0] MAX_EPOCH_X = (EPOCH_W + 1)'(MAX_EPOCH);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               conv_q, conv_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EPOCH_W-1:0] err_q, err_d;

    logic               idx_clr, idx_inc, idx_last;
    logic [ADDR_W-1:0]  idx;

    // Widened so the limit compare cannot alias when epoch_q is all-ones.
    logic [EPOCH_W:0]   epoch_next_x;
    logic               upd;

    perceptron_sample_cnt #(
        .NSAMPLES (NSAMPLES),
        .ADDR_W   (ADDR_W)
    ) u_sample_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .idx  (idx),
        .last (idx_last)
    );

    assign epoch_next_x = {1'b0, epoch_q} + (EPOCH_W + 1)'(1);
    assign upd          = (state_q == S_EVAL) && !eq;

    // The index only moves in EVAL/EPOCH_END, so it is stable across ADDR and LOAD.
    assign sample_addr = idx;
    assign ldX1        = (state_q == S_LOAD);
    assign ldX2        = (state_q == S_LOAD);
    assign ldT         = (state_q == S_LOAD);
    assign ldW1        = upd;
    assign ldW2        = upd;
    assign ldB         = upd;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign epoch_count = epoch_q;
    assign err_count   = err_q;

    // Next-state and registered-output decode for the training sequence.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        conv_d  = conv_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    busy_d  = 1'b1;
                    conv_d  = 1'b0;
                    epoch_d = '0;
                    err_d   = '0;
                    idx_clr = 1'b1;
                end
            end
            S_ADDR: state_d = S_LOAD;
            S_LOAD: state_d = S_EVAL;
            S_EVAL: begin
                if (!eq && (err_q != '1)) begin
                    err_d = err_q + EPOCH_W'(1);
                end
                if (idx_last) begin
                    state_d = S_EPOCH_END;
                end else begin
                    idx_inc = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_EPOCH_END: begin
                if (epoch_q != '1) begin
                    epoch_d = epoch_next_x[EPOCH_W-1:0];
                end
                if (err_q == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b1;
                end else if (epoch_next_x == MAX_EPOCH_X) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b0;
                end else begin
                    state_d = S_ADDR;
                    err_d   = '0;
                    idx_clr = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            epoch_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Randomized scoreboard bench for perceptron_train_ctrl. Each run's
// misclassification pattern is a per-epoch/per-sample error table; the
// expected strobe/done timeline is derived from that table and queued, and
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_perceptron_train_ctrl;

    localparam int N   = 4;
    localparam int ME  = 3;
    localparam int AW  = 2;
    localparam int EW  = 3;
    localparam int EPL = 3 * N + 1;

    typedef struct {
        int kind;   // 0 load, 1 update, 2 done
        int addr;
        int conv;
        int epochs;
        int errs;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, eq;
    logic [AW-1:0] sample_addr;
    logic          ldX1, ldX2, ldT, ldW1, ldW2, ldB;
    logic          busy, done, converged;
    logic [EW-1:0] epoch_count, err_count;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    bit   cur_mask [ME][N];
    int   load_total = 0;
    int   base = 0;
    bit   ld_seen = 1'b0;
    int   ld_idx = 0;
    int   exp_done, exp_conv, exp_ep, exp_err;

    perceptron_train_ctrl #(
        .NSAMPLES (N), .ADDR_W (AW), .MAX_EPOCH (ME), .EPOCH_W (EW)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .eq (eq),
        .sample_addr (sample_addr),
        .ldX1 (ldX1), .ldX2 (ldX2), .ldT (ldT),
        .ldW1 (ldW1), .ldW2 (ldW2), .ldB (ldB),
        .busy (busy), .done (done), .converged (converged),
        .epoch_count (epoch_count), .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Datapath stand-in: eq reflects the sample most recently loaded, random otherwise.
    always @(negedge clk) begin
        ld_seen = ldX1;
        if (ldX1) begin
            ld_idx = load_total - base;
            load_total++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ld_seen) eq = !cur_mask[(ld_idx / N) % ME][ld_idx % N];
        else         eq = 1'($urandom);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t x;
        int   kind;
        if (ldX1 | ldX2 | ldT | ldW1 | ldW2 | ldB | done) begin
            kind = done ? 2 : ((ldW1 | ldW2 | ldB) ? 1 : 0);
            if ((ldX1 | ldX2 | ldT) && (ldW1 | ldW2 | ldB)) begin
                n_cmp++; n_err++;
                $display("FAIL ld_overlap: load and update strobes together (cycle %0d)", cyc);
            end
            if (sbq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_event: kind %0d, none expected (cycle %0d)", kind, cyc);
            end else begin
                x = sbq.pop_front();
                chk("event_kind", kind, x.kind);
                chk("event_cycle", cyc, x.cyc);
                case (x.kind)
                    0: begin
                        chk("ldx_all", int'({ldX1, ldX2, ldT}), 7);
                        chk("load_addr", int'(sample_addr), x.addr);
                        chk("busy_load", int'(busy), 1);
                    end
                    1: begin
                        chk("ldw_all", int'({ldW1, ldW2, ldB}), 7);
                        chk("busy_upd", int'(busy), 1);
                    end
                    default: begin
                        chk("done_conv", int'(converged), x.conv);
                        chk("done_epochs", int'(epoch_count), x.epochs);
                        chk("done_errs", int'(err_count), x.errs);
                        chk("busy_done", int'(busy), 0);
                    end
                endcase
            end
        end
    end

    function automatic void push_ev(int kind, int addr, int conv, int ep, int errs, int c, int cut);
        exp_t x;
        x.kind = kind; x.addr = addr; x.conv = conv; x.epochs = ep; x.errs = errs; x.cyc = c;
        if (c <= cut) sbq.push_back(x);
    endfunction

    // Expected timeline from the error table; start accepted at cycle k.
    task automatic build(input int k, input int cut, output int d_cyc, output int d_conv,
                         output int d_ep, output int d_err);
        int errs;
        d_cyc = 0; d_conv = 0; d_ep = 0; d_err = 0;
        for (int e = 0; e < ME; e++) begin
            errs = 0;
            for (int s = 0; s < N; s++) begin
                push_ev(0, s, 0, 0, 0, k + 1 + EPL * e + 3 * s, cut);
                if (cur_mask[e][s]) begin
                    errs++;
                    push_ev(1, s, 0, 0, 0, k + 2 + EPL * e + 3 * s, cut);
                end
            end
            if (errs == 0 || e == ME - 1) begin
                d_cyc  = k + EPL * (e + 1);
                d_conv = (errs == 0) ? 1 : 0;
                d_ep   = e + 1;
                d_err  = errs;
                push_ev(2, 0, d_conv, d_ep, d_err, d_cyc, cut);
                break;
            end
        end
    endtask

    task automatic set_mask(input int mode);
        for (int e = 0; e < ME; e++)
            for (int s = 0; s < N; s++)
                case (mode)
                    0:       cur_mask[e][s] = 1'b0;
                    1:       cur_mask[e][s] = (e == 0 && s == 2);
                    2:       cur_mask[e][s] = 1'b1;
                    default: cur_mask[e][s] = ($urandom % 4 == 0);
                endcase
    endtask

    // One training run. chain=1: called on the negedge of the previous DONE
    // cycle, start held through DONE (ignored) into IDLE (accepted).
    task automatic run(input bit chain, input bit pulses);
        int k;
        if (chain) begin
            start = 1'b1;
            @(posedge clk);
            @(posedge clk);
        end else begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
        end
        #1;
        k = cyc;
        start = 1'b0;
        base = load_total;
        build(k, 1 << 30, exp_done, exp_conv, exp_ep, exp_err);
        chk("run_busy", int'(busy), 1);
        chk("run_epoch0", int'(epoch_count), 0);
        chk("run_err0", int'(err_count), 0);
        chk("run_conv0", int'(converged), 0);
        chk("run_addr0", int'(sample_addr), 0);
        while (cyc < exp_done) begin
            @(negedge clk);
            start = pulses && (cyc < exp_done) && ($urandom % 6 == 0);
        end
    endtask

    task automatic hold_check();
        repeat (2) @(negedge clk);
        chk("hold_conv", int'(converged), exp_conv);
        chk("hold_epochs", int'(epoch_count), exp_ep);
        chk("hold_errs", int'(err_count), exp_err);
        chk("hold_busy", int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, int'(sample_addr), 0);
        chk({tag, "_ld"}, int'({ldX1, ldX2, ldT, ldW1, ldW2, ldB}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_conv"}, int'(converged), 0);
        chk({tag, "_epochs"}, int'(epoch_count), 0);
        chk({tag, "_errs"}, int'(err_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, l, s, d0, d1, d2, d3;
        rst = 1'b1; start = 1'b0; eq = 1'b0;
        set_mask(0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // all correct, single error, all wrong
        set_mask(0); run(0, 1); hold_check();
        set_mask(1); run(0, 0); hold_check();
        set_mask(2); run(0, 1); hold_check();

        // reset during LOAD of the second epoch
        set_mask(3);
        cur_mask[0][$urandom % N] = 1'b1;
        s = $urandom % N;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
        base = load_total;
        l = k + 1 + EPL + 3 * s;
        build(k, l, d0, d1, d2, d3);
        while (cyc < l) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (4) @(negedge clk);
        set_mask(0); run(0, 0); hold_check();

        // start on DONE ignored, accepted one cycle later
        set_mask(3); run(0, 1);
        set_mask(3); run(1, 1); hold_check();

        repeat (8) begin
            set_mask($urandom % 4);
            if ($urandom % 2 == 1) run(1, 1);
            else begin
                hold_check();
                run(0, 1);
            end
        end
        hold_check();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
